// File: rtl/softmax_pkg.sv
// Shared definitions for the 16-bit softmax datapath: fp16 constants,
// the total-order key used for max selection, and the reduction FSM states.
package softmax_pkg;

   localparam int DATAWIDTH = 16;

   localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
   localparam logic [15:0] FP16_QNAN    = 16'h7E00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic logic is_nan(input logic [15:0] x);
      return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
   endfunction

   // Maps fp16 onto an unsigned key so that plain unsigned compare orders
   // the values, with -0 ranked just below +0.
   function automatic logic [15:0] ord_key(input logic [15:0] x);
      return x[15] ? ~x : (x | 16'h8000);
   endfunction

endpackage

// File: rtl/mode1_max_accum_if.sv
// Beat input / vector-max output bundle of mode1_max_accum.
// master = upstream + downstream side, slave = the reduction block.
interface mode1_max_accum_if
   import softmax_pkg::*;
#(
   parameter int CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 in_last;
   logic [DATAWIDTH-1:0] inp0;
   logic [DATAWIDTH-1:0] inp1;
   logic [DATAWIDTH-1:0] inp2;
   logic [DATAWIDTH-1:0] inp3;
   logic                 max_valid;
   logic                 max_ready;
   logic [DATAWIDTH-1:0] max_out;
   logic [CNT_W-1:0]     beat_cnt;
   logic                 cnt_ovf;

   modport master (
      output in_valid, in_last, inp0, inp1, inp2, inp3, max_ready,
      input  in_ready, max_valid, max_out, beat_cnt, cnt_ovf
   );

   modport slave (
      input  in_valid, in_last, inp0, inp1, inp2, inp3, max_ready,
      output in_ready, max_valid, max_out, beat_cnt, cnt_ovf
   );
endinterface

// File: rtl/mode1_max_cmp.sv
// Two-input fp16 maximum. NaN inputs rank as -inf; on equal keys input a
// (the lower lane index) wins.
module mode1_max_cmp
   import softmax_pkg::*;
(
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic [DATAWIDTH-1:0] y
);
   logic [DATAWIDTH-1:0] a_s;
   logic [DATAWIDTH-1:0] b_s;

   // Sanitise NaNs, then select the larger key.
   always_comb begin
      a_s = is_nan(a) ? FP16_NEG_INF : a;
      b_s = is_nan(b) ? FP16_NEG_INF : b;
      if (ord_key(b_s) > ord_key(a_s)) begin
         y = b_s;
      end else begin
         y = a_s;
      end
   end
endmodule

// File: rtl/mode1_max_accum.sv
// Streaming fp16 max reduction over a vector of 4-lane beats, feeding the
// subtract stage's b operand. Optional macro: MODE1_MAX_NAN_PROPAGATE_EN.
module mode1_max_accum
   import softmax_pkg::*;
#(
   parameter int DATAWIDTH = 16,
   parameter int CNT_W     = 8
)(
   input  logic             clk,
   input  logic             resetn,
   mode1_max_accum_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t               state_r;
   logic                 ready_r;
   logic                 valid_r;
   logic [DATAWIDTH-1:0] max_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 ovf_r;

   logic [DATAWIDTH-1:0] w01_s;
   logic [DATAWIDTH-1:0] w23_s;
   logic [DATAWIDTH-1:0] beat_max_s;
   logic [DATAWIDTH-1:0] run_max_s;
   logic [DATAWIDTH-1:0] cand_s;
   logic [DATAWIDTH-1:0] fin_s;
   logic                 accept_s;

   mode1_max_cmp u_cmp01 (.a(bus.inp0), .b(bus.inp1), .y(w01_s));
   mode1_max_cmp u_cmp23 (.a(bus.inp2), .b(bus.inp3), .y(w23_s));
   mode1_max_cmp u_cmpb  (.a(w01_s),    .b(w23_s),    .y(beat_max_s));
   mode1_max_cmp u_cmpr  (.a(max_r),    .b(beat_max_s), .y(run_max_s));

   assign accept_s = bus.in_valid & ready_r;

`ifdef MODE1_MAX_NAN_PROPAGATE_EN
   logic nan_r;
   logic nan_next_s;

   // Vector NaN flag; a NaN result is presented as the canonical quiet NaN.
   always_comb begin
      cand_s     = (state_r == IDLE) ? beat_max_s : run_max_s;
      nan_next_s = is_nan(bus.inp0) | is_nan(bus.inp1) | is_nan(bus.inp2) | is_nan(bus.inp3)
                 | ((state_r != IDLE) & nan_r);
      if (nan_next_s) begin
         fin_s = FP16_QNAN;
      end else begin
         fin_s = cand_s;
      end
   end

   // Sticky NaN flag, restarted by the first beat of a vector.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         nan_r <= 1'b0;
      end else if (accept_s) begin
         nan_r <= nan_next_s;
      end
   end
`else
   // First beat loads the beat max; later beats fold into the running max.
   always_comb begin
      cand_s = (state_r == IDLE) ? beat_max_s : run_max_s;
      fin_s  = cand_s;
   end
`endif

   // Vector FSM with registered handshake, max and beat-count outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= IDLE;
         ready_r <= 1'b0;
         valid_r <= 1'b0;
         max_r   <= 16'h0000;
         cnt_r   <= {CNT_W{1'b0}};
         ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               ready_r <= 1'b1;
               if (accept_s) begin
                  cnt_r <= CNT_ONE;
                  ovf_r <= 1'b0;
                  if (bus.in_last) begin
                     state_r <= HOLD;
                     ready_r <= 1'b0;
                     valid_r <= 1'b1;
                     max_r   <= fin_s;
                  end else begin
                     state_r <= ACCUM;
                     max_r   <= cand_s;
                  end
               end
            end
            ACCUM: begin
               if (accept_s) begin
                  if (cnt_r == CNT_MAX) begin
                     ovf_r <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
                  if (bus.in_last) begin
                     state_r <= HOLD;
                     ready_r <= 1'b0;
                     valid_r <= 1'b1;
                     max_r   <= fin_s;
                  end else begin
                     max_r   <= cand_s;
                  end
               end
            end
            HOLD: begin
               if (bus.max_ready) begin
                  state_r <= IDLE;
                  valid_r <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               ready_r <= 1'b0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = ready_r;
   assign bus.max_valid = valid_r;
   assign bus.max_out   = max_r;
   assign bus.beat_cnt  = cnt_r;
   assign bus.cnt_ovf   = ovf_r;
endmodule
